// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the pixel-strobe source, the timing generator and the colour logic.
interface vga_timing_gen_if #(
   parameter int unsigned CW = 10
);
   logic          pix_en;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          line_start;
   logic          frame_start;

   modport master (
      input  pix_en,
      output hsync, vsync, video_on, x, y, line_start, frame_start
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, video_on, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-strobe-enabled horizontal/vertical FSMs producing
// registered sync, blanking, coordinates and line/frame start pulses on the system clock.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE   = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_VISIBLE   = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter bit          SYNC_ACTIVE = 1'b0,
   parameter int unsigned CW          = 10
) (
   input logic              clk,
   input logic              reset,
   vga_timing_gen_if.master vga
);

   typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
   typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

   h_state_t      h_state,  h_state_nxt;
   v_state_t      v_state,  v_state_nxt;
   logic [CW-1:0] h_cnt,    h_cnt_nxt;
   logic [CW-1:0] v_cnt,    v_cnt_nxt;
   logic [CW-1:0] x_q,      x_nxt;
   logic [CW-1:0] y_q,      y_nxt;
   logic          hsync_q,  hsync_nxt;
   logic          vsync_q,  vsync_nxt;
   logic          video_q,  video_nxt;
   logic          line_q,   line_nxt;
   logic          frame_q,  frame_nxt;
   logic          h_wrap;
   logic          v_wrap;

   // Reset parks both FSMs one strobe before the raster origin so the first strobe lands on (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_state <= HS_BP;
         v_state <= VS_BP;
         h_cnt   <= CW'(1);
         v_cnt   <= CW'(1);
         x_q     <= CW'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
         y_q     <= CW'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
         hsync_q <= ~SYNC_ACTIVE;
         vsync_q <= ~SYNC_ACTIVE;
         video_q <= 1'b0;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         h_state <= h_state_nxt;
         v_state <= v_state_nxt;
         h_cnt   <= h_cnt_nxt;
         v_cnt   <= v_cnt_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         hsync_q <= hsync_nxt;
         vsync_q <= vsync_nxt;
         video_q <= video_nxt;
         line_q  <= line_nxt;
         frame_q <= frame_nxt;
      end
   end

   always_comb begin
      h_state_nxt = h_state;
      v_state_nxt = v_state;
      h_cnt_nxt   = h_cnt;
      v_cnt_nxt   = v_cnt;
      x_nxt       = x_q;
      y_nxt       = y_q;
      line_nxt    = 1'b0;
      frame_nxt   = 1'b0;
      h_wrap      = 1'b0;
      v_wrap      = 1'b0;

      if (vga.pix_en) begin
         // Each segment counts down its remaining pixels; the last one hands over to the next segment.
         if (h_cnt == CW'(1)) begin
            unique case (h_state)
               HS_ACT:  begin h_state_nxt = HS_FP;   h_cnt_nxt = CW'(H_FP);      end
               HS_FP:   begin h_state_nxt = HS_SYNC; h_cnt_nxt = CW'(H_SYNC);    end
               HS_SYNC: begin h_state_nxt = HS_BP;   h_cnt_nxt = CW'(H_BP);      end
               HS_BP:   begin h_state_nxt = HS_ACT;  h_cnt_nxt = CW'(H_VISIBLE); h_wrap = 1'b1; end
            endcase
         end else begin
            h_cnt_nxt = h_cnt - CW'(1);
         end

         // The vertical FSM steps once per line, on the strobe that wraps x.
         if (h_wrap) begin
            x_nxt = '0;
            if (v_cnt == CW'(1)) begin
               unique case (v_state)
                  VS_ACT:  begin v_state_nxt = VS_FP;   v_cnt_nxt = CW'(V_FP);      end
                  VS_FP:   begin v_state_nxt = VS_SYNC; v_cnt_nxt = CW'(V_SYNC);    end
                  VS_SYNC: begin v_state_nxt = VS_BP;   v_cnt_nxt = CW'(V_BP);      end
                  VS_BP:   begin v_state_nxt = VS_ACT;  v_cnt_nxt = CW'(V_VISIBLE); v_wrap = 1'b1; end
               endcase
            end else begin
               v_cnt_nxt = v_cnt - CW'(1);
            end
            y_nxt = v_wrap ? '0 : y_q + CW'(1);
         end else begin
            x_nxt = x_q + CW'(1);
         end

         line_nxt  = h_wrap;
         frame_nxt = v_wrap;
      end

      // Decoding from next state keeps sync/blanking aligned with the new coordinates.
      hsync_nxt = (h_state_nxt == HS_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_nxt = (v_state_nxt == VS_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_nxt = (h_state_nxt == HS_ACT) && (v_state_nxt == VS_ACT);
   end

   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.video_on    = video_q;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny active-high-sync instance,
// both checked every clock against an arithmetic raster model indexed by strobe count.
module tb_vga_timing_gen;

   localparam int unsigned S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 4;
   localparam int unsigned S_VV = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;
   localparam int unsigned S_VT = S_VV + S_VF + S_VS + S_VB;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
      logic        hs;
      logic        vs;
      logic        von;
      logic        ls;
      logic        fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.CW(10)) d_if ();
   vga_timing_gen_if #(.CW(5))  s_if ();

   vga_timing_gen u_dflt (.clk(clk), .reset(reset), .vga(d_if.master));

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .SYNC_ACTIVE(1'b1), .CW(5)
   ) u_small (.clk(clk), .reset(reset), .vga(s_if.master));

   int     n_cmp = 0;
   int     n_err = 0;
   longint n     = 0;
   bit     strobe = 1'b0;

   longint last_ls, last_fs;
   int     hrun, vs_cnt, n_lp, n_fp, n_hrun, n_vsf;
   bit     in_hrun, vs_valid, prev_dh, prev_sv;

   // Raster position after n strobes since reset; n=0 is the parked pre-origin position.
   function automatic exp_t model(input longint cnt, input bit stb,
                                  input longint hv, hf, hs, hb, vv, vf, vs, vb, input bit sa);
      exp_t   e;
      longint ht, vt, lin, xx, yy;
      ht  = hv + hf + hs + hb;
      vt  = vv + vf + vs + vb;
      lin = (cnt + ht * vt - 1) % (ht * vt);
      xx  = lin % ht;
      yy  = lin / ht;
      e.x   = 32'(xx);
      e.y   = 32'(yy);
      e.hs  = (xx >= hv + hf && xx < hv + hf + hs) ? sa : ~sa;
      e.vs  = (yy >= vv + vf && yy < vv + vf + vs) ? sa : ~sa;
      e.von = (xx < hv) && (yy < vv);
      e.ls  = stb && (xx == 0);
      e.fs  = stb && (xx == 0) && (yy == 0);
      return e;
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s at strobe %0d: observed %0d, expected %0d", tag, n, obs, exp_v);
      end
   endtask

   task automatic check_all();
      exp_t e;
      e = model(n, strobe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      cmp("dflt.x",           32'(d_if.x),           e.x);
      cmp("dflt.y",           32'(d_if.y),           e.y);
      cmp("dflt.hsync",       32'(d_if.hsync),       32'(e.hs));
      cmp("dflt.vsync",       32'(d_if.vsync),       32'(e.vs));
      cmp("dflt.video_on",    32'(d_if.video_on),    32'(e.von));
      cmp("dflt.line_start",  32'(d_if.line_start),  32'(e.ls));
      cmp("dflt.frame_start", 32'(d_if.frame_start), 32'(e.fs));
      e = model(n, strobe, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1);
      cmp("small.x",           32'(s_if.x),           e.x);
      cmp("small.y",           32'(s_if.y),           e.y);
      cmp("small.hsync",       32'(s_if.hsync),       32'(e.hs));
      cmp("small.vsync",       32'(s_if.vsync),       32'(e.vs));
      cmp("small.video_on",    32'(s_if.video_on),    32'(e.von));
      cmp("small.line_start",  32'(s_if.line_start),  32'(e.ls));
      cmp("small.frame_start", 32'(s_if.frame_start), 32'(e.fs));
   endtask

   task automatic clear_trackers();
      last_ls  = -1;
      last_fs  = -1;
      in_hrun  = 1'b0;
      vs_valid = 1'b0;
      vs_cnt   = 0;
      prev_dh  = 1'b1;
      prev_sv  = 1'b0;
   endtask

   // Interval-level properties measured from the DUT outputs on each strobe.
   task automatic track();
      if (d_if.line_start) begin
         if (last_ls >= 0) begin cmp("dflt.line_period", 32'(n - last_ls), 32'd800); n_lp++; end
         last_ls = n;
      end
      if (d_if.hsync == 1'b0) begin
         if (prev_dh) begin
            cmp("dflt.hsync_start_x", 32'(d_if.x), 32'd656);
            hrun = 1; in_hrun = 1'b1;
         end else if (in_hrun) begin
            hrun++;
         end
      end else if (!prev_dh && in_hrun) begin
         cmp("dflt.hsync_width", 32'(hrun), 32'd96);
         in_hrun = 1'b0; n_hrun++;
      end
      if (s_if.frame_start) begin
         if (last_fs >= 0) begin cmp("small.frame_period", 32'(n - last_fs), 32'(S_HT * S_VT)); n_fp++; end
         if (vs_valid) begin cmp("small.vsync_strobes", 32'(vs_cnt), 32'(S_VS * S_HT)); n_vsf++; end
         last_fs = n; vs_valid = 1'b1; vs_cnt = 0;
      end
      if (s_if.vsync) begin
         if (!prev_sv) begin
            cmp("small.vsync_start_x", 32'(s_if.x), 32'd0);
            cmp("small.vsync_start_y", 32'(s_if.y), 32'(S_VV + S_VF));
         end
         vs_cnt++;
      end
   endtask

   task automatic tick(input bit pe);
      d_if.pix_en = pe;
      s_if.pix_en = pe;
      @(posedge clk);
      #1;
      strobe = pe;
      if (pe) n++;
      check_all();
      if (pe) track();
      prev_dh = d_if.hsync;
      prev_sv = s_if.vsync;
   endtask

   // Reset asserted between clock edges; outputs must change without any edge.
   task automatic async_reset();
      d_if.pix_en = 1'b0;
      s_if.pix_en = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      n = 0;
      strobe = 1'b0;
      check_all();
      clear_trackers();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int guard;
      exp_t e;
      n_lp = 0; n_fp = 0; n_hrun = 0; n_vsf = 0; hrun = 0;
      clear_trackers();
      reset = 1'b1;
      d_if.pix_en = 1'b0;
      s_if.pix_en = 1'b0;

      // Power-on reset and hold with pix_en low after release.
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick(1'b0);

      // First strobe then pulses drop.
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);

      // Back-to-back strobes across two lines.
      repeat (1700) tick(1'b1);

      // 1-in-4 strobe spacing.
      repeat (850) begin
         tick(1'b1);
         repeat (3) tick(1'b0);
      end

      // Advance to x=300 on the default raster, then reset mid-line.
      guard = 0;
      e = model(n, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      while (e.x != 32'd300 && guard < 1000) begin
         tick(1'b1);
         guard++;
         e = model(n, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      end
      cmp("reach_x300", 32'(d_if.x), 32'd300);
      async_reset();
      repeat (2) tick(1'b0);
      tick(1'b1);
      tick(1'b0);

      // Random gaps of 0..7 idle clocks between strobes.
      repeat (1000) begin
         repeat ($urandom_range(0, 7)) tick(1'b0);
         tick(1'b1);
      end

      cmp("dflt.line_periods_seen", 32'(n_lp > 0),  32'd1);
      cmp("dflt.hsync_runs_seen",   32'(n_hrun > 0), 32'd1);
      cmp("small.frames_seen",      32'(n_fp >= 2), 32'd1);
      cmp("small.vsync_frames_seen", 32'(n_vsf >= 2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
